// File: rtl/mcp01_pkg.sv
// Shared encodings for the MCP01 control unit: opcodes, ALU functions,
// FSM states and the control-vector bundle driven into the datapath.
package mcp01_pkg;

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned ALUC_W = 2;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPC_W-1:0] OP_NOT  = 3'b011;
  localparam logic [OPC_W-1:0] OP_PUSH = 3'b100;
  localparam logic [OPC_W-1:0] OP_POP  = 3'b101;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b110;
  localparam logic [OPC_W-1:0] OP_JZ   = 3'b111;

  localparam logic [ALUC_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUC_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUC_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALUC_W-1:0] ALU_NOT = 2'b11;

  typedef enum logic [4:0] {
    StRst   = 5'd0,
    StIf    = 5'd1,
    StId    = 5'd2,
    StPop1  = 5'd3,
    StPop2  = 5'd4,
    StLd2   = 5'd5,
    StPop1n = 5'd6,
    StLd1   = 5'd7,
    StExec  = 5'd8,
    StPushr = 5'd9,
    StMrd   = 5'd10,
    StPshm  = 5'd11,
    StPops  = 5'd12,
    StMwr   = 5'd13,
    StJmp   = 5'd14,
    StTos   = 5'd15,
    StJzs   = 5'd16
  } state_e;

  typedef struct packed {
    logic              iord;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              pc_write;
    logic              pc_sel;
    logic              jz;
    logic              d_in_sel;
    logic              push;
    logic              pop;
    logic              tos;
    logic              ldop1;
    logic              ldop2;
    logic              alu_src_a;
    logic              alu_src_b;
    logic [ALUC_W-1:0] alu_control;
    logic              instr_done;
  } ctrl_t;

  // Dispatch target out of ID for a given opcode.
  function automatic state_e id_next(input logic [OPC_W-1:0] opc);
    state_e nxt;
    case (opc)
      OP_ADD, OP_SUB, OP_AND: nxt = StPop1;
      OP_NOT:                 nxt = StPop1n;
      OP_PUSH:                nxt = StMrd;
      OP_POP:                 nxt = StPops;
      OP_JMP:                 nxt = StJmp;
      default:                nxt = StTos;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mcp01_ctrl_decode.sv
// Combinational decode of the current FSM state (plus the ALU opcode bits,
// used only in EXEC) into the full datapath control vector.
module mcp01_ctrl_decode
  import mcp01_pkg::*;
(
  input  state_e            state_i,
  input  logic [ALUC_W-1:0] alu_op_i,
  output ctrl_t             ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StIf: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ir_write = 1'b1;
        ctrl_o.pc_write = 1'b1;
      end
      StPop1, StPop1n, StPops: begin
        ctrl_o.pop = 1'b1;
      end
      StPop2: begin
        ctrl_o.pop   = 1'b1;
        ctrl_o.ldop1 = 1'b1;
      end
      StLd2: begin
        ctrl_o.ldop2 = 1'b1;
      end
      StLd1: begin
        ctrl_o.ldop1 = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a   = 1'b1;
        ctrl_o.alu_src_b   = 1'b1;
        ctrl_o.alu_control = alu_op_i;
      end
      StPushr: begin
        ctrl_o.push       = 1'b1;
        ctrl_o.d_in_sel   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMrd: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      StPshm: begin
        ctrl_o.push       = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMwr: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StJmp: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_sel     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StTos: begin
        ctrl_o.tos = 1'b1;
      end
      StJzs: begin
        // PC load is conditional on d_out == 0, handled in the datapath.
        ctrl_o.jz         = 1'b1;
        ctrl_o.pc_sel     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcp01_controller.sv
// MCP01 multicycle control unit: state register and next-state sequencing;
// control outputs come from mcp01_ctrl_decode.
module mcp01_controller
  import mcp01_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IR_Write,
  output logic              PC_Write,
  output logic              PCsel,
  output logic              JZ,
  output logic              d_in_sel,
  output logic              push,
  output logic              pop,
  output logic              tos,
  output logic              ldop1,
  output logic              ldop2,
  output logic              ALU_Src_A,
  output logic              ALU_Src_B,
  output logic [ALUC_W-1:0] ALU_Control,
  output logic              instr_done
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRst;
    case (state_q)
      StRst:   state_d = StIf;
      StIf:    state_d = StId;
      StId:    state_d = id_next(opcode);
      StPop1:  state_d = StPop2;
      StPop2:  state_d = StLd2;
      StLd2:   state_d = StExec;
      StPop1n: state_d = StLd1;
      StLd1:   state_d = StExec;
      StExec:  state_d = StPushr;
      StMrd:   state_d = StPshm;
      StPops:  state_d = StMwr;
      StTos:   state_d = StJzs;
      StPushr, StPshm, StMwr, StJmp, StJzs: state_d = StIf;
      default: state_d = StRst;
    endcase
  end

  mcp01_ctrl_decode u_decode (
    .state_i  (state_q),
    .alu_op_i (opcode[ALUC_W-1:0]),
    .ctrl_o   (ctrl)
  );

  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IR_Write    = ctrl.ir_write;
  assign PC_Write    = ctrl.pc_write;
  assign PCsel       = ctrl.pc_sel;
  assign JZ          = ctrl.jz;
  assign d_in_sel    = ctrl.d_in_sel;
  assign push        = ctrl.push;
  assign pop         = ctrl.pop;
  assign tos         = ctrl.tos;
  assign ldop1       = ctrl.ldop1;
  assign ldop2       = ctrl.ldop2;
  assign ALU_Src_A   = ctrl.alu_src_a;
  assign ALU_Src_B   = ctrl.alu_src_b;
  assign ALU_Control = ctrl.alu_control;
  assign instr_done  = ctrl.instr_done;

endmodule

// File: tb/tb_mcp01_controller.sv
// Directed bench for mcp01_controller: per-cycle control vectors for every
// instruction class, plus asynchronous reset in the middle of an ADD.
module tb_mcp01_controller;
  import mcp01_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       IorD, MemRead, MemWrite, IR_Write, PC_Write, PCsel, JZ, d_in_sel;
  logic       push, pop, tos, ldop1, ldop2, ALU_Src_A, ALU_Src_B, instr_done;
  logic [1:0] ALU_Control;

  mcp01_controller dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IR_Write    (IR_Write),
    .PC_Write    (PC_Write),
    .PCsel       (PCsel),
    .JZ          (JZ),
    .d_in_sel    (d_in_sel),
    .push        (push),
    .pop         (pop),
    .tos         (tos),
    .ldop1       (ldop1),
    .ldop2       (ldop2),
    .ALU_Src_A   (ALU_Src_A),
    .ALU_Src_B   (ALU_Src_B),
    .ALU_Control (ALU_Control),
    .instr_done  (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed MSB..LSB in port order.
  logic [17:0] outs;
  assign outs = {IorD, MemRead, MemWrite, IR_Write, PC_Write, PCsel, JZ, d_in_sel, push, pop,
                 tos, ldop1, ldop2, ALU_Src_A, ALU_Src_B, ALU_Control, instr_done};

  localparam logic [17:0] M_IORD  = 18'h1 << 17;
  localparam logic [17:0] M_MRD   = 18'h1 << 16;
  localparam logic [17:0] M_MWR   = 18'h1 << 15;
  localparam logic [17:0] M_IRW   = 18'h1 << 14;
  localparam logic [17:0] M_PCW   = 18'h1 << 13;
  localparam logic [17:0] M_PCSEL = 18'h1 << 12;
  localparam logic [17:0] M_JZ    = 18'h1 << 11;
  localparam logic [17:0] M_DSEL  = 18'h1 << 10;
  localparam logic [17:0] M_PUSH  = 18'h1 << 9;
  localparam logic [17:0] M_POP   = 18'h1 << 8;
  localparam logic [17:0] M_TOS   = 18'h1 << 7;
  localparam logic [17:0] M_LD1   = 18'h1 << 6;
  localparam logic [17:0] M_LD2   = 18'h1 << 5;
  localparam logic [17:0] M_SA    = 18'h1 << 4;
  localparam logic [17:0] M_SB    = 18'h1 << 3;
  localparam logic [17:0] M_DONE  = 18'h1;

  localparam logic [17:0] V_IF    = M_MRD | M_IRW | M_PCW;
  localparam logic [17:0] V_ID    = 18'h0;
  localparam logic [17:0] V_PUSHR = M_PUSH | M_DSEL | M_DONE;

  function automatic logic [17:0] exec_v(input logic [1:0] alu);
    return M_SA | M_SB | {15'b0, alu, 1'b0};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered at a negedge where the next posedge starts IF.
  task automatic run_instr(input string name, input logic [2:0] opc,
                           input logic [17:0] exp [8], input int n, input bit scramble);
    opcode = opc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_c%0d", name, i + 1), {14'b0, outs}, {14'b0, exp[i]});
      if (scramble && i == 2) opcode = ~opc;
    end
  endtask

  logic [17:0] seq [8];

  initial begin
    rst    = 1'b1;
    opcode = OP_ADD;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outs", {14'b0, outs}, 32'h0);
    end
    rst = 1'b1;
    check("rst_state_after_release", {14'b0, outs}, 32'h0);

    seq = '{V_IF, V_ID, M_POP, M_POP | M_LD1, M_LD2, exec_v(ALU_SUB), V_PUSHR, 18'h0};
    run_instr("sub", OP_SUB, seq, 7, 1'b0);

    seq = '{V_IF, V_ID, M_POP, M_LD1, exec_v(ALU_NOT), V_PUSHR, 18'h0, 18'h0};
    run_instr("not", OP_NOT, seq, 6, 1'b0);

    seq = '{V_IF, V_ID, M_IORD | M_MRD, M_PUSH | M_DONE, 18'h0, 18'h0, 18'h0, 18'h0};
    run_instr("push", OP_PUSH, seq, 4, 1'b1);

    seq = '{V_IF, V_ID, M_POP, M_IORD | M_MWR | M_DONE, 18'h0, 18'h0, 18'h0, 18'h0};
    run_instr("pop", OP_POP, seq, 4, 1'b1);

    seq = '{V_IF, V_ID, M_TOS, M_JZ | M_PCSEL | M_DONE, 18'h0, 18'h0, 18'h0, 18'h0};
    run_instr("jz", OP_JZ, seq, 4, 1'b1);

    seq = '{V_IF, V_ID, M_PCW | M_PCSEL | M_DONE, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
    run_instr("jmp", OP_JMP, seq, 3, 1'b1);

    seq = '{V_IF, V_ID, M_POP, M_POP | M_LD1, M_LD2, exec_v(ALU_AND), V_PUSHR, 18'h0};
    run_instr("and", OP_AND, seq, 7, 1'b0);

    // ADD interrupted by reset while in POP2.
    seq = '{V_IF, V_ID, M_POP, M_POP | M_LD1, 18'h0, 18'h0, 18'h0, 18'h0};
    run_instr("add_part", OP_ADD, seq, 4, 1'b0);
    #2 rst = 1'b0;
    #1 check("async_rst_outs", {14'b0, outs}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("held_rst_outs", {14'b0, outs}, 32'h0);
      check("held_rst_no_push", {31'b0, push}, 32'h0);
    end
    rst = 1'b1;
    check("post_rst_state", {14'b0, outs}, 32'h0);

    seq = '{V_IF, V_ID, M_POP, M_POP | M_LD1, M_LD2, exec_v(ALU_ADD), V_PUSHR, 18'h0};
    run_instr("add", OP_ADD, seq, 7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
